// File: rtl/sha2_pkg.sv
`default_nettype none
// sha2_pkg -- SHA-2 round-constant tables (word 0 in the MS position) and sequencer state type. Rev 1.0
package sha2_pkg;

  localparam int ROUNDS_256 = 64;
  localparam int ROUNDS_512 = 80;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } seq_state_e;

  localparam logic [ROUNDS_256*32-1:0] K256_TABLE = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [ROUNDS_512*64-1:0] K512_TABLE = {
    64'h428a2f98d728ae22, 64'h7137449123ef65cd, 64'hb5c0fbcfec4d3b2f, 64'he9b5dba58189dbbc,
    64'h3956c25bf348b538, 64'h59f111f1b605d019, 64'h923f82a4af194f9b, 64'hab1c5ed5da6d8118,
    64'hd807aa98a3030242, 64'h12835b0145706fbe, 64'h243185be4ee4b28c, 64'h550c7dc3d5ffb4e2,
    64'h72be5d74f27b896f, 64'h80deb1fe3b1696b1, 64'h9bdc06a725c71235, 64'hc19bf174cf692694,
    64'he49b69c19ef14ad2, 64'hefbe4786384f25e3, 64'h0fc19dc68b8cd5b5, 64'h240ca1cc77ac9c65,
    64'h2de92c6f592b0275, 64'h4a7484aa6ea6e483, 64'h5cb0a9dcbd41fbd4, 64'h76f988da831153b5,
    64'h983e5152ee66dfab, 64'ha831c66d2db43210, 64'hb00327c898fb213f, 64'hbf597fc7beef0ee4,
    64'hc6e00bf33da88fc2, 64'hd5a79147930aa725, 64'h06ca6351e003826f, 64'h142929670a0e6e70,
    64'h27b70a8546d22ffc, 64'h2e1b21385c26c926, 64'h4d2c6dfc5ac42aed, 64'h53380d139d95b3df,
    64'h650a73548baf63de, 64'h766a0abb3c77b2a8, 64'h81c2c92e47edaee6, 64'h92722c851482353b,
    64'ha2bfe8a14cf10364, 64'ha81a664bbc423001, 64'hc24b8b70d0f89791, 64'hc76c51a30654be30,
    64'hd192e819d6ef5218, 64'hd69906245565a910, 64'hf40e35855771202a, 64'h106aa07032bbd1b8,
    64'h19a4c116b8d2d0c8, 64'h1e376c085141ab53, 64'h2748774cdf8eeb99, 64'h34b0bcb5e19b48a8,
    64'h391c0cb3c5c95a63, 64'h4ed8aa4ae3418acb, 64'h5b9cca4f7763e373, 64'h682e6ff3d6b2b8a3,
    64'h748f82ee5defb2fc, 64'h78a5636f43172f60, 64'h84c87814a1f0ab72, 64'h8cc702081a6439ec,
    64'h90befffa23631e28, 64'ha4506cebde82bde9, 64'hbef9a3f7b2c67915, 64'hc67178f2e372532b,
    64'hca273eceea26619c, 64'hd186b8c721c0c207, 64'heada7dd6cde0eb1e, 64'hf57d4f7fee6ed178,
    64'h06f067aa72176fba, 64'h0a637dc5a2c898a6, 64'h113f9804bef90dae, 64'h1b710b35131c471b,
    64'h28db77f523047d84, 64'h32caab7b40c72493, 64'h3c9ebe0a15c9bebc, 64'h431d67c49c100d4c,
    64'h4cc5d4becb3e42b6, 64'h597f299cfc657e2a, 64'h5fcb6fab3ad6faec, 64'h6c44198c4a475817
  };

endpackage
`default_nettype wire

// File: rtl/sha2_k_rom.sv
`default_nettype none
// sha2_k_rom -- combinational SHA-2 round-constant lookup; out-of-range index reads as zero. Rev 1.0
module sha2_k_rom
  import sha2_pkg::*;
#(
  parameter int VARIANT = 0,
  parameter int RND_W = 7,
  localparam int WORD_W = (VARIANT == 1) ? 64 : 32,
  localparam int ROUNDS = (VARIANT == 1) ? ROUNDS_512 : ROUNDS_256
) (
  input  logic [RND_W-1:0]  idx,
  output logic [WORD_W-1:0] word
);

  localparam int TBL_W = WORD_W * ROUNDS;

  logic [TBL_W-1:0] k_table;
  logic [12:0]      offset;

  if (VARIANT == 1) begin : g_k512
    assign k_table = K512_TABLE;
  end else begin : g_k256
    assign k_table = K256_TABLE;
  end

  // 13-bit offset: the 80x64 table needs bit positions up to 5119.
  always_comb begin
    word   = '0;
    offset = '0;
    if (int'(idx) < ROUNDS) begin
      offset = 13'(WORD_W) * (13'(ROUNDS - 1) - 13'(idx));
      word   = k_table[offset +: WORD_W];
    end
  end

endmodule
`default_nettype wire

// File: rtl/sha2_k_sequencer.sv
`default_nettype none
// sha2_k_sequencer -- streams SHA-2 round constants K[0..ROUNDS-1] over a valid/ready handshake. Rev 1.0
module sha2_k_sequencer
  import sha2_pkg::*;
#(
  parameter int VARIANT = 0,
  parameter int RND_W = 7,
  localparam int WORD_W = (VARIANT == 1) ? 64 : 32,
  localparam int ROUNDS = (VARIANT == 1) ? ROUNDS_512 : ROUNDS_256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              k_valid,
  input  logic              k_ready,
  output logic [WORD_W-1:0] k_word,
  output logic [RND_W-1:0]  k_round,
  output logic              k_last,
  output logic              done
);

  localparam logic [RND_W-1:0] LAST_IDX = RND_W'(ROUNDS - 1);

  if (VARIANT != 0 && VARIANT != 1) begin : g_bad_variant
    $error("sha2_k_sequencer: VARIANT must be 0 or 1");
  end
  if ((2 ** RND_W) < ROUNDS) begin : g_bad_rnd_w
    $error("sha2_k_sequencer: RND_W too narrow for ROUNDS");
  end

  seq_state_e        state;
  logic [RND_W-1:0]  rom_idx;
  logic [WORD_W-1:0] rom_word;

  // Look up the word for the next round so it registers together with k_round.
  assign rom_idx = (state == ST_RUN) ? k_round + RND_W'(1) : '0;

  sha2_k_rom #(
    .VARIANT (VARIANT),
    .RND_W   (RND_W)
  ) u_rom (
    .idx  (rom_idx),
    .word (rom_word)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      busy    <= 1'b0;
      k_valid <= 1'b0;
      k_word  <= '0;
      k_round <= '0;
      k_last  <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start && !abort) begin
            state   <= ST_RUN;
            busy    <= 1'b1;
            k_valid <= 1'b1;
            k_round <= '0;
            k_word  <= rom_word;
            k_last  <= (LAST_IDX == '0);
          end
        end
        ST_RUN: begin
          if (abort || (k_ready && k_last)) begin
            state   <= ST_IDLE;
            busy    <= 1'b0;
            k_valid <= 1'b0;
            k_word  <= '0;
            k_round <= '0;
            k_last  <= 1'b0;
            done    <= !abort;
          end else if (k_ready) begin
            k_round <= rom_idx;
            k_word  <= rom_word;
            k_last  <= (rom_idx == LAST_IDX);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sha2_k_sequencer.sv
`default_nettype none
// tb_sha2_k_sequencer -- checks both SHA-2 variants against constants derived from cube roots of primes. Rev 1.0
module tb_sha2_k_sequencer;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        start   [2];
  logic        abort   [2];
  logic        k_ready [2];
  logic        busy    [2];
  logic        k_valid [2];
  logic        k_last  [2];
  logic        done    [2];
  logic [6:0]  k_round [2];
  logic [31:0] k_word_256;
  logic [63:0] k_word_512;
  logic [63:0] kw      [2];

  assign kw[0] = {32'd0, k_word_256};
  assign kw[1] = k_word_512;

  always #5 clock = ~clock;

  sha2_k_sequencer #(.VARIANT(0), .RND_W(7)) u_dut256 (
    .clock(clock), .reset_n(reset_n), .start(start[0]), .abort(abort[0]),
    .busy(busy[0]), .k_valid(k_valid[0]), .k_ready(k_ready[0]), .k_word(k_word_256),
    .k_round(k_round[0]), .k_last(k_last[0]), .done(done[0])
  );

  sha2_k_sequencer #(.VARIANT(1), .RND_W(7)) u_dut512 (
    .clock(clock), .reset_n(reset_n), .start(start[1]), .abort(abort[1]),
    .busy(busy[1]), .k_valid(k_valid[1]), .k_ready(k_ready[1]), .k_word(k_word_512),
    .k_round(k_round[1]), .k_last(k_last[1]), .done(done[1])
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc = 0;
  bit          chk_en = 1'b0;
  logic [63:0] k64 [80];

  // K[i] = first 64 fraction bits of cbrt(prime_i); the 32-bit family is the upper half.
  function automatic logic [63:0] kconst(input int p);
    logic [255:0] n, x, c;
    n = 256'(p) << 192;
    x = '0;
    for (int b = 67; b >= 0; b--) begin
      c = x | (256'(1) << b);
      if (c * c * c <= n) x = c;
    end
    return x[63:0];
  endfunction

  function automatic bit is_prime(input int n);
    for (int d = 2; d * d <= n; d++)
      if (n % d == 0) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int rounds(input int i);
    return (i == 0) ? 64 : 80;
  endfunction

  function automatic logic [63:0] k_exp(input int i, input int r);
    return (i == 0) ? {32'd0, k64[r][63:32]} : k64[r];
  endfunction

  task automatic check(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %h, expected %h", nm, inst, act, exp);
    end
  endtask

  // Behavioural model: running flag, current round, done pulse.
  bit m_run  [2] = '{1'b0, 1'b0};
  int m_rnd  [2] = '{0, 0};
  bit m_done [2] = '{1'b0, 1'b0};

  always @(posedge clock) begin
    cyc <= cyc + 1;
    for (int i = 0; i < 2; i++) begin
      if (!reset_n) begin
        m_run[i]  <= 1'b0;
        m_rnd[i]  <= 0;
        m_done[i] <= 1'b0;
      end else begin
        m_done[i] <= 1'b0;
        if (!m_run[i]) begin
          if (start[i] && !abort[i]) begin
            m_run[i] <= 1'b1;
            m_rnd[i] <= 0;
          end
        end else if (abort[i]) begin
          m_run[i] <= 1'b0;
        end else if (k_ready[i]) begin
          if (m_rnd[i] == rounds(i) - 1) begin
            m_run[i]  <= 1'b0;
            m_done[i] <= 1'b1;
          end else begin
            m_rnd[i] <= m_rnd[i] + 1;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (chk_en) begin
      for (int i = 0; i < 2; i++) begin
        check("busy", i, 64'(busy[i]), 64'(m_run[i]));
        check("k_valid", i, 64'(k_valid[i]), 64'(m_run[i]));
        check("done", i, 64'(done[i]), 64'(m_done[i]));
        if (m_run[i]) begin
          check("k_word", i, kw[i], k_exp(i, m_rnd[i]));
          check("k_round", i, 64'(k_round[i]), 64'(m_rnd[i]));
          check("k_last", i, 64'(k_last[i]), 64'(m_rnd[i] == rounds(i) - 1));
        end
      end
    end
  end

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic wait_round(input int i, input int r);
    int t = 0;
    while (!(k_valid[i] === 1'b1 && int'(k_round[i]) == r) && t < 200) begin
      tick();
      t++;
    end
    check("reach_round", i, 64'(k_round[i]), 64'(r));
  endtask

  task automatic wait_done(input int i, input int s, input int exp_len);
    int t = 0;
    while (done[i] !== 1'b1 && t < 400) begin
      tick();
      t++;
    end
    check("done_seen", i, 64'(done[i]), 64'd1);
    check("run_len", i, 64'(cyc - s), 64'(exp_len));
    check("busy_at_done", i, 64'(busy[i]), 64'd0);
  endtask

  task automatic restart_and_clear(input int i);
    start[i] = 1'b1;
    tick();
    start[i] = 1'b0;
    check("restart_valid", i, 64'(k_valid[i]), 64'd1);
    check("restart_round", i, 64'(k_round[i]), 64'd0);
    check("restart_word", i, kw[i], (i == 0) ? 64'h428a2f98 : 64'h428a2f98d728ae22);
    abort[i] = 1'b1;
    tick();
    abort[i] = 1'b0;
  endtask

  task automatic full_run(input int i, input bit hold_start);
    int s;
    k_ready[i] = 1'b1;
    start[i] = 1'b1;
    s = cyc;
    tick();
    start[i] = hold_start;
    check("beat0_word", i, kw[i], (i == 0) ? 64'h428a2f98 : 64'h428a2f98d728ae22);
    if (i == 0) begin
      wait_round(0, 16);
      check("beat16_word", 0, kw[0], 64'he49b69c1);
    end
    wait_round(i, rounds(i) - 1);
    check("last_word", i, kw[i], (i == 0) ? 64'hc67178f2 : 64'h6c44198c4a475817);
    check("last_flag", i, 64'(k_last[i]), 64'd1);
    wait_done(i, s, rounds(i) + 1);
    restart_and_clear(i);
  endtask

  initial begin
    int p = 1;
    bit seen;
    int s;
    reset_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; k_ready[i] = 1'b0;
    end
    for (int k = 0; k < 80; k++) begin
      do p++; while (!is_prime(p));
      k64[k] = kconst(p);
    end
    check("model_k64_0", 1, k64[0], 64'h428a2f98d728ae22);
    check("model_k64_79", 1, k64[79], 64'h6c44198c4a475817);
    check("model_k32_5", 0, k_exp(0, 5), 64'h59f111f1);
    check("model_k32_63", 0, k_exp(0, 63), 64'hc67178f2);

    repeat (3) tick();
    for (int i = 0; i < 2; i++) begin
      check("rst_busy", i, 64'(busy[i]), 64'd0);
      check("rst_valid", i, 64'(k_valid[i]), 64'd0);
      check("rst_word", i, kw[i], 64'd0);
      check("rst_round", i, 64'(k_round[i]), 64'd0);
      check("rst_last", i, 64'(k_last[i]), 64'd0);
      check("rst_done", i, 64'(done[i]), 64'd0);
    end
    reset_n = 1'b1;
    chk_en = 1'b1;
    tick();

    full_run(0, 1'b0);
    full_run(1, 1'b0);
    full_run(0, 1'b1);

    // Backpressure: hold off three cycles at round 5.
    k_ready[0] = 1'b1;
    start[0] = 1'b1;
    s = cyc;
    tick();
    start[0] = 1'b0;
    wait_round(0, 5);
    k_ready[0] = 1'b0;
    repeat (3) begin
      tick();
      check("stall_word", 0, kw[0], 64'h59f111f1);
      check("stall_valid", 0, 64'(k_valid[0]), 64'd1);
    end
    k_ready[0] = 1'b1;
    tick();
    check("after_stall_word", 0, kw[0], 64'h923f82a4);
    check("after_stall_round", 0, 64'(k_round[0]), 64'd6);
    wait_done(0, s, 68);

    // Abort at round 10: no done pulse, then a clean restart.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_round(0, 10);
    abort[0] = 1'b1;
    tick();
    abort[0] = 1'b0;
    check("abort_valid", 0, 64'(k_valid[0]), 64'd0);
    check("abort_busy", 0, 64'(busy[0]), 64'd0);
    seen = 1'b0;
    repeat (100) begin
      tick();
      if (done[0] === 1'b1) seen = 1'b1;
    end
    check("abort_no_done", 0, 64'(seen), 64'd0);
    restart_and_clear(0);

    // Reset mid-run at round 30.
    start[0] = 1'b1;
    tick();
    start[0] = 1'b0;
    wait_round(0, 30);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check("mid_rst_busy", 0, 64'(busy[0]), 64'd0);
    check("mid_rst_valid", 0, 64'(k_valid[0]), 64'd0);
    check("mid_rst_word", 0, kw[0], 64'd0);
    check("mid_rst_round", 0, 64'(k_round[0]), 64'd0);
    check("mid_rst_last", 0, 64'(k_last[0]), 64'd0);
    check("mid_rst_done", 0, 64'(done[0]), 64'd0);

    // Random traffic on both instances, checked every cycle by the model.
    repeat (4000) begin
      tick();
      reset_n = ($urandom_range(0, 499) != 0);
      for (int i = 0; i < 2; i++) begin
        k_ready[i] = ($urandom_range(0, 3) != 0);
        start[i]   = ($urandom_range(0, 7) == 0);
        abort[i]   = ($urandom_range(0, 63) == 0);
      end
    end
    reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0; abort[i] = 1'b0; k_ready[i] = 1'b0;
    end
    repeat (2) tick();
    chk_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/sha2_k_sequencer.md
Name: sha2_k_sequencer

Overview:
Streams the SHA-2 round constants K[0..ROUNDS-1] one word per accepted beat, under a start/abort command interface and a valid/ready output handshake with backpressure. It generalises the fixed 32-bit, 64-entry constant lookup to both the SHA-256 and SHA-512 families, selected by parameter. It sits beside the message-schedule/compression datapath of a SHA-2 core, which consumes one K per round.

Parameters:
VARIANT, 0, 0 = SHA-224/256 (WORD_W=32, ROUNDS=64); 1 = SHA-384/512 (WORD_W=64, ROUNDS=80); any other value is an elaboration error
WORD_W, derived (32|64), constant word width; localparam, not overridable
ROUNDS, derived (64|80), number of constants per run; localparam
RND_W, 7, round-index width; must satisfy 2^RND_W >= ROUNDS

Ports:
clock  input  1  single clock, rising edge
reset_n  input  1  synchronous active-low reset
start  input  1  begin a run; sampled only when idle
abort  input  1  terminate the current run; priority over all other inputs except reset
busy  output  1  high from the cycle after an accepted start until the run ends
k_valid  output  1  k_word, k_round and k_last are valid
k_ready  input  1  consumer accepts the beat when k_valid && k_ready
k_word  output  WORD_W  constant K[k_round]
k_round  output  RND_W  round index of the current beat
k_last  output  1  high when k_round == ROUNDS-1
done  output  1  one-cycle pulse after the final beat is accepted

Behaviour:
- Reset (reset_n low at a rising edge): state IDLE; busy=0, k_valid=0, k_word=0, k_round=0, k_last=0, done=0. Applies mid-run; the run is discarded with no done pulse.
- States: IDLE, RUN.
- IDLE: start=1 and abort=0 -> RUN next cycle with k_valid=1, k_round=0, k_word=K[0], busy=1. Latency from start to first valid beat: 1 cycle. start with abort=1 is ignored.
- RUN: on a handshake with k_round < ROUNDS-1, k_round increments next cycle and k_word is updated. With no handshake, k_word, k_round and k_last hold stable (AXI-style: valid is never withdrawn except by abort or reset).
- RUN: a handshake with k_round == ROUNDS-1 -> IDLE next cycle: k_valid=0, busy=0, done=1 for exactly that one cycle, k_round returns to 0.
- start is ignored while in RUN. start asserted in the done cycle (state already IDLE) is accepted, so back-to-back runs have a one-cycle gap with no valid beat.
- abort=1 in RUN -> IDLE next cycle: k_valid=0, busy=0, done=0. A handshake in the abort cycle still counts as accepted by the consumer, but no further beats are issued.
- Throughput: 1 beat/cycle with k_ready held high; a full run takes ROUNDS+1 cycles from start to done.
- k_word, k_round and k_last are registered outputs; no combinational path from k_ready to the outputs.
- Table indexing: the constants are stored as one packed vector, word 0 in the MS position. Word r = table[WORD_W*(ROUNDS-1-r) +: WORD_W]. The index arithmetic is computed at width >= 13 bits to avoid truncation for 80x64.
- The next-word lookup uses the incremented index so k_word is registered together with k_round.

Decomposition:
- Package sha2_pkg: localparams K256_TABLE (64x32 packed) and K512_TABLE (80x64 packed), plus the constants ROUNDS_256=64, ROUNDS_512=80. The SHA-512 table upper halves equal the cube-root constants; each full 64-bit value is stored explicitly.
- Sub-module sha2_k_rom: a purely combinational lookup (params VARIANT; in: idx[RND_W]; out: word[WORD_W]). Out-of-range idx returns 0.
- sha2_k_sequencer contains the FSM, round counter, output registers and the handshake.

Test Plan:
- VARIANT=0, k_ready=1, pulse start -> 64 consecutive beats. Beat 0 = 32'h428a2f98, beat 16 = 32'he49b69c1, beat 63 = 32'hc67178f2 with k_last=1. done pulses 65 cycles after start, then busy=0.
- VARIANT=1, k_ready=1 -> 80 beats. Beat 0 = 64'h428a2f98d728ae22, beat 79 = 64'h6c44198c4a475817 with k_last=1, done after 81 cycles.
- VARIANT=0, drop k_ready for 3 cycles while k_round=5 -> k_word holds 32'h59f111f1 and k_valid stays 1. Round 6 (32'h923f82a4) follows one cycle after k_ready rises. Total run length +3.
- Abort at k_round=10 -> next cycle k_valid=0, busy=0, done never pulses. A subsequent start restarts at round 0 with 32'h428a2f98.
- reset_n low for 1 cycle at k_round=30 -> all outputs 0 next cycle. start during RUN is ignored (k_round does not restart). start in the done cycle yields round 0 one cycle later.
